param_fifo: RTL and testbench
=============================

// Module: param_fifo
// PURPOSE
//   Parametrised synchronous FIFO; successor to the fixed 8x32 FIFO. Generic width/depth, almost-full/
//   almost-empty thresholds, and same-cycle read+write at the full and empty boundaries. Sits between a
//   producer and consumer on one clock domain. Per-op ack/err pulses and an op-state register kept for compatibility.
// PARAMETERS
//   DATA_WIDTH  32  data word width in bits
//   DEPTH_LOG2  3   log2 of the depth; DEPTH = 2**DEPTH_LOG2 (default 8 entries)
//   AF_LEVEL    6   almost_full asserts when data_count >= AF_LEVEL
//   AE_LEVEL    2   almost_empty asserts when data_count <= AE_LEVEL
// PORTS
//   clk           in   1             rising-edge clock
//   reset         in   1             asynchronous, active-high reset
//   rd_en         in   1             read request
//   wr_en         in   1             write request
//   din           in   DATA_WIDTH    write data
//   dout          out  DATA_WIDTH    read data, registered
//   data_count    out  DEPTH_LOG2+1  occupancy, 0..DEPTH
//   full/empty    out  1             data_count==DEPTH / data_count==0
//   almost_full   out  1             data_count >= AF_LEVEL
//   almost_empty  out  1             data_count <= AE_LEVEL
//   wr_ack/wr_err out  1             one-cycle pulse: previous-cycle write accepted / rejected
//   rd_ack/rd_err out  1             one-cycle pulse: previous-cycle read accepted / rejected
//   op_state      out  3             last operation (fifo_pkg encoding)
// BEHAVIOUR
//   - Reset (async, any time, mid-operation included): pointers=0, data_count=0, dout=0, empty=1,
//     almost_empty=1, full=0, almost_full=0, all ack/err=0, op_state=INIT. Memory contents are not cleared.
//   - All outputs are registered. Flags are derived from the next-state count, so they are valid in the
//     same cycle as the updated data_count.
//   - Accept rules, evaluated at the clock edge on the pre-edge count:
//       rd_ok = rd_en & ~empty
//       wr_ok = wr_en & (~full | rd_ok)   // write into a full FIFO succeeds only with a concurrent read
//   - Empty + both requests: write accepted, read rejected (rd_err). No fall-through.
//   - Full + both requests: both accepted; data_count stays at DEPTH.
//   - Read latency is 1: dout <= mem[rd_ptr] on the accepting edge, with rd_ack in the same cycle. On a
//     rejected read or idle cycle, dout holds its last value.
//   - Write: mem[wr_ptr] <= din; wr_ptr increments.
//   - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
//   - data_count += wr_ok - rd_ok.
//   - op_state, priority order: INIT (after reset until first request), then WRITE/WR_ERROR if wr_en,
//     READ/RD_ERROR if rd_en alone, RDWR if both accepted, NO_OP if no request.
//   - Errors never change pointers, count, or memory.
// CONFIGURATION
//   `FIFO_PEAK_EN defined: adds ports peak_clr (in,1) and peak_count (out,DEPTH_LOG2+1).
//     - peak_count holds the maximum data_count since reset or since peak_clr.
//     - A cycle with peak_clr high loads the current post-edge data_count.
//     - Reset value 0.
//   `FIFO_PEAK_EN undefined: neither port exists and no peak logic is built.
// STRUCTURE
//   - fifo_pkg: op_state localparams INIT=0, NO_OP=1, WRITE=2, WR_ERROR=3, READ=4, RD_ERROR=5, RDWR=6;
//     count-width helper constant.
//   - Sub-module fifo_ram: DEPTH x DATA_WIDTH register file with synchronous write and registered read
//     port, driven by rd_ok/wr_ok.
//   - Top level holds the pointers, count, flags, ack/err and op_state.
// TESTING (defaults: 32x8, AF=6, AE=2)
//   1. Reset; write 1..8 on 8 consecutive cycles -> wr_ack each cycle; count 1..8; almost_full at count 6;
//      full at 8. 9th write (9) -> wr_err, count stays 8, op_state=WR_ERROR.
//   2. From full, read 8 -> dout 1..8 in order, rd_ack each cycle, empty at 0. 9th read -> rd_err,
//      dout holds 8.
//   3. Full + rd_en & wr_en (din=0xA) -> both ack, count stays 8, dout=head; 0xA emerges after the
//      remaining 7 words.
//   4. Empty + rd_en & wr_en (din=0x5) -> wr_ack, rd_err, count=1; next read returns 0x5.
//   5. Wrap: write 5 / read 5, then write 0x10..0x17 / read all -> order preserved across pointer wrap.
//   6. Reset asserted mid-burst (count=4) -> async clear; empty=1, count=0, op_state=INIT. With
//      FIFO_PEAK_EN: peak_count=0 after reset, 8 after scenario 1, current count after peak_clr.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for param_fifo and its storage sub-module:
//   - op_state_e : encoding of the last-operation register exposed on op_state
//   - count_width: width of an occupancy counter able to hold 0..2**depth_log2
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5,
    RDWR     = 3'd6
  } op_state_e;

  // The count must reach DEPTH itself, hence one bit wider than the pointers.
  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   DEPTH x DATA_WIDTH register file, one synchronous write port and one read
//   port with a registered output. The read register holds its value when no
//   read is requested.
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (clears rd_data only)
//   wr_en    in   write strobe (already qualified by the FIFO accept logic)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe (already qualified by the FIFO accept logic)
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; clearing it would cost a reset
  // fan-out to every bit and nothing ever reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking assignment here means a read of the slot being written
  // in the same edge (full FIFO, read+write) returns the old head, as required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//   Parametrised single-clock FIFO with registered flags, per-operation
//   ack/err pulses and a last-operation register.
//   Optional build macro: FIFO_PEAK_EN adds peak-occupancy tracking
//   (ports peak_clr / peak_count).
// Parameters
//   DATA_WIDTH  data word width
//   DEPTH_LOG2  log2 of the number of entries
//   AF_LEVEL    almost_full when data_count >= AF_LEVEL
//   AE_LEVEL    almost_empty when data_count <= AE_LEVEL
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   rd_en, wr_en, din      read / write requests and write data
//   dout                   registered read data (1-cycle latency)
//   data_count             occupancy 0..DEPTH
//   full, empty            occupancy == DEPTH / == 0
//   almost_full/empty      threshold flags
//   wr_ack/wr_err          pulse: write of previous cycle accepted / rejected
//   rd_ack/rd_err          pulse: read of previous cycle accepted / rejected
//   op_state               last operation, fifo_pkg::op_state_e encoding
//   peak_clr, peak_count   (FIFO_PEAK_EN only) peak occupancy tracking
// -----------------------------------------------------------------------------
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_LOG2:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            op_state
`ifdef FIFO_PEAK_EN
  ,
  input  logic                  peak_clr,
  output logic [DEPTH_LOG2:0]   peak_count
`endif
);

  localparam int CNT_W = count_width(DEPTH_LOG2);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(2 ** DEPTH_LOG2);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic                  rd_ok, wr_ok;
  op_state_e             op_q, op_nxt;

  // Accept decisions use the registered flags, i.e. the pre-edge occupancy.
  // A full FIFO may still take a write when a read frees a slot in the same edge.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_en  (rd_ok),
    .rd_addr(rd_ptr),
    .rd_data(dout)
  );

  // Pointers, count and flags. Flags are computed from count_nxt so they line
  // up with the registered data_count instead of lagging it by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_CNT);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      wr_ack       <= wr_ok;
      wr_err       <= wr_en & ~wr_ok;
      rd_ack       <= rd_ok;
      rd_err       <= rd_en & ~rd_ok;
    end
  end

  assign data_count = count;

  // Last-operation register. INIT persists until the first request after reset.
  always_comb begin
    op_nxt = op_q;
    if (wr_ok && rd_ok)     op_nxt = RDWR;
    else if (wr_en)         op_nxt = wr_ok ? WRITE : WR_ERROR;
    else if (rd_en)         op_nxt = rd_ok ? READ : RD_ERROR;
    else if (op_q != INIT)  op_nxt = NO_OP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) op_q <= INIT;
    else       op_q <= op_nxt;
  end

  assign op_state = op_q;

`ifdef FIFO_PEAK_EN
  // Tracks the post-edge occupancy so peak_count never lags data_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     peak_count <= '0;
    else if (peak_clr)             peak_count <= count_nxt;
    else if (count_nxt > peak_count) peak_count <= count_nxt;
  end
`else
  // Peak tracking not built in this configuration.
`endif

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
//   Directed self-checking bench for param_fifo at default parameters
//   (32 bits x 8 entries, AF=6, AE=2). Works with or without FIFO_PEAK_EN.
// -----------------------------------------------------------------------------
module tb_param_fifo;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0]  op_state;
`ifdef FIFO_PEAK_EN
  logic        peak_clr;
  logic [3:0]  peak_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  param_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .din         (din),
    .dout        (dout),
    .data_count  (data_count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .rd_ack      (rd_ack),
    .rd_err      (rd_err),
    .op_state    (op_state)
`ifdef FIFO_PEAK_EN
    ,
    .peak_clr    (peak_clr),
    .peak_count  (peak_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests and return 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_peak(input string tag, input logic [3:0] expected);
`ifdef FIFO_PEAK_EN
    check(tag, 32'(peak_count), 32'(expected));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    din   = '0;
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;

    // Reset state
    check("rst_count",  32'(data_count), 0);
    check("rst_empty",  32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full",   32'(full), 0);
    check("rst_afull",  32'(almost_full), 0);
    check("rst_dout",   dout, 0);
    check("rst_ackerr", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 0);
    check("rst_op",     32'(op_state), 32'(INIT));
    check_peak("rst_peak", 0);
    step(0, 0, 0);
    check("idle_after_rst_op", 32'(op_state), 32'(INIT));

    // 1. Fill with 1..8, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 32'(i));
      check("s1_wr_ack", 32'(wr_ack), 1);
      check("s1_count",  32'(data_count), 32'(i));
      check("s1_afull",  32'(almost_full), 32'(i >= 6));
      check("s1_aempty", 32'(almost_empty), 32'(i <= 2));
      check("s1_full",   32'(full), 32'(i == 8));
      check("s1_op",     32'(op_state), 32'(WRITE));
    end
    step(1, 0, 9);
    check("s1_ovf_err",   32'(wr_err), 1);
    check("s1_ovf_ack",   32'(wr_ack), 0);
    check("s1_ovf_count", 32'(data_count), 8);
    check("s1_ovf_op",    32'(op_state), 32'(WR_ERROR));
    check_peak("s1_peak", 8);

    // 2. Drain, then underflow attempt
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0);
      check("s2_rd_ack", 32'(rd_ack), 1);
      check("s2_dout",   dout, 32'(i));
      check("s2_count",  32'(data_count), 32'(8 - i));
      check("s2_empty",  32'(empty), 32'(i == 8));
      check("s2_op",     32'(op_state), 32'(READ));
    end
    step(0, 1, 0);
    check("s2_udf_err",  32'(rd_err), 1);
    check("s2_udf_ack",  32'(rd_ack), 0);
    check("s2_udf_dout", dout, 8);
    check("s2_udf_op",   32'(op_state), 32'(RD_ERROR));
    step(0, 0, 0);
    check("s2_idle_op",   32'(op_state), 32'(NO_OP));
    check("s2_idle_dout", dout, 8);
    check("s2_idle_err",  32'(rd_err), 0);

    // 3. Full + read & write
    for (int i = 1; i <= 8; i++) step(1, 0, 32'(i));
    check("s3_full", 32'(full), 1);
    step(1, 1, 32'hA);
    check("s3_wr_ack", 32'(wr_ack), 1);
    check("s3_rd_ack", 32'(rd_ack), 1);
    check("s3_count",  32'(data_count), 8);
    check("s3_full2",  32'(full), 1);
    check("s3_dout",   dout, 1);
    check("s3_op",     32'(op_state), 32'(RDWR));
    for (int i = 2; i <= 8; i++) begin
      step(0, 1, 0);
      check("s3_drain", dout, 32'(i));
    end
    step(0, 1, 0);
    check("s3_last",  dout, 32'hA);
    check("s3_empty", 32'(empty), 1);

    // 4. Empty + read & write: no fall-through
    step(1, 1, 32'h5);
    check("s4_wr_ack", 32'(wr_ack), 1);
    check("s4_rd_err", 32'(rd_err), 1);
    check("s4_rd_ack", 32'(rd_ack), 0);
    check("s4_count",  32'(data_count), 1);
    check("s4_dout",   dout, 32'hA);
    check("s4_op",     32'(op_state), 32'(WRITE));
    step(0, 1, 0);
    check("s4_read",   dout, 32'h5);
    check("s4_empty",  32'(empty), 1);

    // 5. Pointer wrap (pointers start mid-array here), peak_clr mid-fill
    for (int i = 0; i < 5; i++) step(1, 0, 32'h30 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      check("s5_pre", dout, 32'h30 + 32'(i));
    end
    for (int i = 0; i < 3; i++) step(1, 0, 32'h10 + 32'(i));
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b1;
    step(0, 0, 0);
    peak_clr = 1'b0;
    check_peak("s5_peak_clr", 3);
`endif
    for (int i = 3; i < 8; i++) step(1, 0, 32'h10 + 32'(i));
    check("s5_full", 32'(full), 1);
    check_peak("s5_peak_full", 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      check("s5_wrap", dout, 32'h10 + 32'(i));
    end
    check("s5_empty", 32'(empty), 1);

    // 6. Async reset mid-burst
    for (int i = 0; i < 4; i++) step(1, 0, 32'h40 + 32'(i));
    check("s6_count_pre", 32'(data_count), 4);
    wr_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("s6_count", 32'(data_count), 0);
    check("s6_empty", 32'(empty), 1);
    check("s6_op",    32'(op_state), 32'(INIT));
    check("s6_dout",  dout, 0);
    check_peak("s6_peak", 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0);
    check("s6_idle_op",    32'(op_state), 32'(INIT));
    check("s6_idle_count", 32'(data_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
